// File: rtl/jt49_noise_chk_if.sv
// Bus between a noise source and the JT49 noise-stream checker.
// Macro JT49_NOISE_CHK_PERIOD_EN adds per_meas (cen cycles between samples).
// Ports (master = source side, slave = checker side):
//   cen, bit_vld, noise, clr        source -> checker
//   locked, err, err_cnt, miss      checker -> source
//   per_meas                        checker -> source (macro only)
interface jt49_noise_chk_if #(
  parameter int unsigned ECW = 16
);
  logic           cen;
  logic           bit_vld;
  logic           noise;
  logic           clr;
  logic           locked;
  logic           err;
  logic [ECW-1:0] err_cnt;
  logic [3:0]     miss;
`ifdef JT49_NOISE_CHK_PERIOD_EN
  logic [5:0]     per_meas;

  modport master (
    output cen, bit_vld, noise, clr,
    input  locked, err, err_cnt, miss, per_meas
  );
  modport slave (
    input  cen, bit_vld, noise, clr,
    output locked, err, err_cnt, miss, per_meas
  );
`else
  modport master (
    output cen, bit_vld, noise, clr,
    input  locked, err, err_cnt, miss
  );
  modport slave (
    input  cen, bit_vld, noise, clr,
    output locked, err, err_cnt, miss
  );
`endif
endinterface

// File: rtl/jt49_noise_chk.sv
// Receive-side checker for the JT49 17-bit noise LFSR stream.
// Fills a 17-bit history from the received bits, then predicts every next
// bit, flagging and counting mismatches; drops back to FILL after MISS_MAX
// consecutive misses.
// Optional feature: define JT49_NOISE_CHK_PERIOD_EN to add per_meas.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of jt49_noise_chk_if:
//          cen, bit_vld, noise, clr in; locked, err, err_cnt, miss
//          (and per_meas with the macro) out, all registered
module jt49_noise_chk #(
  parameter int unsigned MISS_MAX = 4,
  parameter int unsigned ECW      = 16
) (
  input  logic             clk,
  input  logic             rst,
  jt49_noise_chk_if.slave  bus
);

  localparam int unsigned HW = 17;
  localparam int unsigned FW = 5;
  localparam int unsigned MW = 4;

  typedef enum logic {ST_FILL, ST_LOCK} state_t;

  state_t         state, state_n;
  logic [HW-1:0]  hist, hist_n;
  logic [FW-1:0]  fcnt, fcnt_n;
  logic [MW-1:0]  miss, miss_n;
  logic [ECW-1:0] err_cnt, err_cnt_n;
  logic           err, err_n;
  logic           locked, locked_n;

  logic s_c, r_c, pred_c;

  // Sample strike, received bit with generator inversion removed, prediction
  assign s_c    = bus.cen & bus.bit_vld;
  assign r_c    = ~bus.noise;
  assign pred_c = hist[16] ^ hist[13] ^ (hist == '0);

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FILL;
      hist    <= '0;
      fcnt    <= '0;
      miss    <= '0;
      err_cnt <= '0;
      err     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_n;
      hist    <= hist_n;
      fcnt    <= fcnt_n;
      miss    <= miss_n;
      err_cnt <= err_cnt_n;
      err     <= err_n;
      locked  <= locked_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n   = state;
    hist_n    = hist;
    fcnt_n    = fcnt;
    miss_n    = miss;
    err_cnt_n = err_cnt;
    err_n     = err;
    if (bus.cen) begin
      err_n = 1'b0;
      // History always takes the received bit so the checker re-syncs itself
      if (s_c) hist_n = {hist[HW-2:0], r_c};
      if (bus.clr) begin
        state_n   = ST_FILL;
        fcnt_n    = '0;
        miss_n    = '0;
        err_cnt_n = '0;
      end else if (s_c) begin
        unique case (state)
          ST_FILL: begin
            if (fcnt == FW'(HW - 1)) begin
              state_n = ST_LOCK;
              fcnt_n  = '0;
              miss_n  = '0;
            end else begin
              fcnt_n = fcnt + FW'(1);
            end
          end
          ST_LOCK: begin
            if (r_c == pred_c) begin
              miss_n = '0;
            end else begin
              err_n = 1'b1;
              if (err_cnt != '1) err_cnt_n = err_cnt + ECW'(1);
              if (miss + MW'(1) == MW'(MISS_MAX)) begin
                state_n = ST_FILL;
                fcnt_n  = '0;
                miss_n  = '0;
              end else begin
                miss_n = miss + MW'(1);
              end
            end
          end
          default: state_n = ST_FILL;
        endcase
      end
    end
    locked_n = (state_n == ST_LOCK);
  end

  assign bus.locked  = locked;
  assign bus.err     = err;
  assign bus.err_cnt = err_cnt;
  assign bus.miss    = miss;

`ifdef JT49_NOISE_CHK_PERIOD_EN
  localparam int unsigned PW = 6;

  logic [PW-1:0] pcnt, pcnt_n;
  logic [PW-1:0] per_meas, per_meas_n;

  // Counts cen cycles between samples; per_meas latches the gap on each sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt     <= '0;
      per_meas <= '0;
    end else begin
      pcnt     <= pcnt_n;
      per_meas <= per_meas_n;
    end
  end

  always_comb begin
    pcnt_n     = pcnt;
    per_meas_n = per_meas;
    if (s_c) begin
      per_meas_n = (pcnt == '1) ? pcnt : pcnt + PW'(1);
      pcnt_n     = '0;
    end else if (bus.cen && pcnt != '1) begin
      pcnt_n = pcnt + PW'(1);
    end
  end

  assign bus.per_meas = per_meas;
`endif

endmodule
